decoder_rr_arbiter: RTL and testbench
=====================================

Name: decoder_rr_arbiter

Overview:
Round-robin arbiter that shares one 2-to-4 decoder-driven resource among four requesters. It drives the decoder's 2-bit select and enable, and exposes the equivalent one-hot grant vector. Each requester holds its grant while it keeps its request asserted. A hold timer preempts long holders when others are waiting, so no requester starves.

Parameters:
MAX_HOLD, 8, max consecutive grant cycles before forced release if another request is pending; 0 disables preemption
CNT_W, 4, hold counter width; MAX_HOLD must be < 2**CNT_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
arb_en  input  1  global arbiter enable; low forces all grants off
req  input  4  request per requester, bit i = requester i, level-held while using the resource
dec_sel  output  2  registered index of granted requester, to decoder in
dec_en  output  1  registered grant valid, to decoder en
gnt  output  4  one-hot grant; equals (1 << dec_sel) when dec_en=1, else 4'b0000
busy  output  1  high while in GRANT (equals dec_en)
preempt  output  1  one-cycle pulse when a grant was forcibly ended by the hold timer

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n): sampled only on the rising clk edge.
- Reset values: dec_sel=2'b00, dec_en=0, gnt=0000, busy=0, preempt=0, priority pointer ptr=0, hold counter=0, state=IDLE.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - dec_en=0.
  - If arb_en=1 and req!=0, pick the first set bit in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: load dec_sel with the winner, set dec_en=1, clear the counter, go to GRANT.
  - Latency: request sampled at edge N gives gnt visible after edge N (one cycle).
- GRANT:
  - The counter increments each cycle and saturates at 2**CNT_W-1.
  - Exits, in priority order, each evaluated at the edge:
    1. arb_en=0: go to IDLE, dec_en=0, ptr unchanged, preempt=0.
    2. req[dec_sel]=0 (release): go to IDLE, ptr = dec_sel+1 mod 4, preempt=0.
    3. MAX_HOLD!=0, gnt has been high MAX_HOLD cycles, and another req bit is set: go to IDLE, ptr = dec_sel+1 mod 4, preempt=1 for exactly that IDLE cycle.
    4. Otherwise stay in GRANT with dec_sel stable.
- Hold timer without contention: if the hold limit is reached and no other request is pending, the grant continues indefinitely. Preemption fires later, as soon as another request appears.
- Break-before-make: every grant ends with at least one IDLE cycle with dec_en=0. Consequence: gnt never switches directly between requesters, and is never multi-hot.
- dec_sel holds its last value while dec_en=0; it updates only on entry to GRANT.
- Simultaneous release and hold limit: treated as a release, so preempt stays 0.
- Requests from non-granted requesters have no effect during GRANT except to enable preemption.
- Preempted requester: if it is still requesting, it re-enters arbitration at the lowest priority.
- rst_n low mid-grant: all state returns to reset values at that edge, and ptr returns to 0.

Test Plan:
1. Reset then single request: rst_n=0 for 2 cycles, release; req=0010 held 5 cycles, then 0000 → dec_en=0/gnt=0000 during reset; dec_sel=01, gnt=0010 from the edge after req rises; gnt high 5 cycles; dec_en=0 one cycle after req drops.
2. Round-robin rotation: req=1111, each requester drops its bit 3 cycles after being granted and re-raises it next cycle → grant order 0,1,2,3,0 with exactly one dec_en=0 cycle between grants.
3. Preemption: MAX_HOLD=8; req=0001 held forever, req[2] raised at cycle 3 of grant 0 → gnt=0001 for exactly 8 cycles, then one IDLE cycle with preempt=1, then gnt=0100.
4. No-contention hold: MAX_HOLD=8, req=1000 only for 20 cycles → gnt=1000 continuously for 20 cycles, preempt never asserts.
5. arb_en and tie cases: release and hold limit on the same edge → preempt=0. arb_en=0 mid-grant of requester 2 → dec_en=0 next cycle; re-enable with req=0101 → requester 2 wins again (ptr unchanged).
6. Reset mid-grant: grant active on requester 3, rst_n=0 for one edge with req=1111 held → all outputs reset; after release, requester 0 is granted first.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for a 2-to-4 decoder-driven shared resource.
// Holders keep the grant while requesting; a hold timer preempts under contention.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [3:0] req,
  output logic [1:0] dec_sel,
  output logic       dec_en,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       win;
  logic             hold_hit;
  logic             others;

  // pick first requester at or after ptr, wrapping around
  always_comb begin
    logic [1:0] off;
    win = 2'd0;
    off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      off = ptr + 2'(i);
      if (req[off]) win = off;
    end
  end

  assign gnt      = dec_en ? (4'b0001 << dec_sel) : 4'b0000;
  assign busy     = dec_en;
  assign others   = |(req & ~gnt);
  assign hold_hit = (MAX_HOLD != 0) && (cnt >= HOLD_LAST);

  // arbiter state machine with registered decoder outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      cnt     <= '0;
      dec_sel <= 2'd0;
      dec_en  <= 1'b0;
      preempt <= 1'b0;
    end else begin
      preempt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_en && |req) begin
            state   <= GRANT;
            dec_sel <= win;
            dec_en  <= 1'b1;
            cnt     <= '0;
          end
        end
        GRANT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (!arb_en) begin
            state  <= IDLE;
            dec_en <= 1'b0;
          end else if (!req[dec_sel]) begin
            state  <= IDLE;
            dec_en <= 1'b0;
            ptr    <= dec_sel + 2'd1;
          end else if (hold_hit && others) begin
            state   <= IDLE;
            dec_en  <= 1'b0;
            ptr     <= dec_sel + 2'd1;
            preempt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter.
// Cycle vectors: inputs applied, one edge, then outputs compared.
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       arb_en;
  logic [3:0] req;
  logic [1:0] dec_sel;
  logic       dec_en;
  logic [3:0] gnt;
  logic       busy;
  logic       preempt;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       exp_en;
    logic [1:0] exp_sel;
    logic       exp_pre;
  } vec_t;

  vec_t tbl[$];

  decoder_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .req     (req),
    .dec_sel (dec_sel),
    .dec_en  (dec_en),
    .gnt     (gnt),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [3:0] q,
                     input logic xe, input logic [1:0] xs, input logic xp);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = q;
    v.exp_en = xe; v.exp_sel = xs; v.exp_pre = xp;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic e,
                      input logic [3:0] q, input logic xe,
                      input logic [1:0] xs, input logic xp);
    logic [3:0] xg;
    rst_n = r; arb_en = e; req = q;
    @(posedge clk);
    #1;
    xg = xe ? (4'b0001 << xs) : 4'b0000;
    cmp({nm, ".dec_en"}, {3'b0, dec_en}, {3'b0, xe});
    cmp({nm, ".dec_sel"}, {2'b0, dec_sel}, {2'b0, xs});
    cmp({nm, ".gnt"}, gnt, xg);
    cmp({nm, ".busy"}, {3'b0, busy}, {3'b0, xe});
    cmp({nm, ".preempt"}, {3'b0, preempt}, {3'b0, xp});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; arb_en = 1'b1; req = 4'b0000;

    // single request after reset
    add(0, 1, 4'b0000, 0, 2'd0, 0);
    add(0, 1, 4'b0000, 0, 2'd0, 0);
    add(1, 1, 4'b0010, 1, 2'd1, 0);
    add(1, 1, 4'b0010, 1, 2'd1, 0);
    add(1, 1, 4'b0010, 1, 2'd1, 0);
    add(1, 1, 4'b0010, 1, 2'd1, 0);
    add(1, 1, 4'b0010, 1, 2'd1, 0);
    add(1, 1, 4'b0000, 0, 2'd1, 0);
    // rotation 0,1,2,3,0 from a fresh pointer
    add(0, 1, 4'b0000, 0, 2'd0, 0);
    add(1, 1, 4'b1111, 1, 2'd0, 0);
    add(1, 1, 4'b1111, 1, 2'd0, 0);
    add(1, 1, 4'b1111, 1, 2'd0, 0);
    add(1, 1, 4'b1110, 0, 2'd0, 0);
    add(1, 1, 4'b1111, 1, 2'd1, 0);
    add(1, 1, 4'b1111, 1, 2'd1, 0);
    add(1, 1, 4'b1111, 1, 2'd1, 0);
    add(1, 1, 4'b1101, 0, 2'd1, 0);
    add(1, 1, 4'b1111, 1, 2'd2, 0);
    add(1, 1, 4'b1111, 1, 2'd2, 0);
    add(1, 1, 4'b1111, 1, 2'd2, 0);
    add(1, 1, 4'b1011, 0, 2'd2, 0);
    add(1, 1, 4'b1111, 1, 2'd3, 0);
    add(1, 1, 4'b1111, 1, 2'd3, 0);
    add(1, 1, 4'b1111, 1, 2'd3, 0);
    add(1, 1, 4'b0111, 0, 2'd3, 0);
    add(1, 1, 4'b1111, 1, 2'd0, 0);
    add(1, 1, 4'b0000, 0, 2'd0, 0);

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].en, tbl[i].req,
           tbl[i].exp_en, tbl[i].exp_sel, tbl[i].exp_pre);

    // preemption after exactly 8 held cycles
    step("pre_rst", 0, 1, 4'b0000, 0, 2'd0, 0);
    for (int k = 1; k <= 8; k++)
      step($sformatf("pre_hold%0d", k), 1, 1,
           (k >= 3) ? 4'b0101 : 4'b0001, 1, 2'd0, 0);
    step("pre_pulse", 1, 1, 4'b0101, 0, 2'd0, 1);
    step("pre_next", 1, 1, 4'b0101, 1, 2'd2, 0);
    step("pre_rel", 1, 1, 4'b0000, 0, 2'd2, 0);

    // no contention: hold forever, preempt once contention shows up
    step("nc_rst", 0, 1, 4'b0000, 0, 2'd0, 0);
    for (int k = 1; k <= 20; k++)
      step($sformatf("nc_hold%0d", k), 1, 1, 4'b1000, 1, 2'd3, 0);
    step("nc_pulse", 1, 1, 4'b1001, 0, 2'd3, 1);
    step("nc_next", 1, 1, 4'b1001, 1, 2'd0, 0);
    step("nc_rel", 1, 1, 4'b0000, 0, 2'd0, 0);

    // release coinciding with the hold limit
    step("tie_rst", 0, 1, 4'b0000, 0, 2'd0, 0);
    for (int k = 1; k <= 8; k++)
      step($sformatf("tie_hold%0d", k), 1, 1, 4'b0011, 1, 2'd0, 0);
    step("tie_rel", 1, 1, 4'b0010, 0, 2'd0, 0);
    step("tie_next", 1, 1, 4'b0010, 1, 2'd1, 0);
    step("tie_done", 1, 1, 4'b0000, 0, 2'd1, 0);

    // arb_en drop mid-grant keeps the pointer
    step("en_g2a", 1, 1, 4'b0100, 1, 2'd2, 0);
    step("en_g2b", 1, 1, 4'b0100, 1, 2'd2, 0);
    step("en_off", 1, 0, 4'b0100, 0, 2'd2, 0);
    step("en_offidle", 1, 0, 4'b0100, 0, 2'd2, 0);
    step("en_back", 1, 1, 4'b0101, 1, 2'd2, 0);
    step("en_rel", 1, 1, 4'b0000, 0, 2'd2, 0);

    // reset in the middle of a grant to requester 3
    step("mr_g3", 1, 1, 4'b1111, 1, 2'd3, 0);
    step("mr_rst", 0, 1, 4'b1111, 0, 2'd0, 0);
    step("mr_after", 1, 1, 4'b1111, 1, 2'd0, 0);
    step("mr_rel", 1, 1, 4'b0000, 0, 2'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
